// File: rtl/checksum.sv
// Serial CRC-8 frame checker: 64 payload bits then 8 CRC bits, LSB first, one bit per enabled clock.
// Result is registered on the edge that samples the last frame bit; en_i low simply stalls the frame.
module checksum #(
  parameter int unsigned          DATA_WIDTH = 64,
  parameter int unsigned          CRC_WIDTH  = 8,
  parameter logic [CRC_WIDTH-1:0] POLY       = 8'h07
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  en_i,
  input  logic                  data_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  flag_o
);

  localparam int unsigned      FRAME_LEN   = DATA_WIDTH + CRC_WIDTH;
  localparam int unsigned      CNT_W       = $clog2(FRAME_LEN);
  localparam logic [CNT_W-1:0] LAST_BIT    = CNT_W'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0] PAYLOAD_END = CNT_W'(DATA_WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  logic [CNT_W-1:0]      bit_cnt;
  logic [CRC_WIDTH-1:0]  crc;
  logic [CRC_WIDTH-2:0]  rx_crc;
  logic [CRC_WIDTH-1:0]  rx_full;
  logic [DATA_WIDTH-1:0] payload;
  logic                  in_payload;
  logic                  fb;

  // The top received-CRC bit is the live input on the completion edge, so only 7 bits are stored.
  always_comb begin
    in_payload = (bit_cnt < PAYLOAD_END);
    fb         = crc[CRC_WIDTH-1] ^ data_i;
    rx_full    = {data_i, rx_crc};
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      bit_cnt <= '0;
      crc     <= '0;
      rx_crc  <= '0;
      payload <= '0;
      data_o  <= '0;
      flag_o  <= 1'b0;
    end else if (en_i) begin
      if (in_payload) begin
        payload <= {data_i, payload[DATA_WIDTH-1:1]};
        crc     <= {crc[CRC_WIDTH-2:0], 1'b0} ^ (fb ? POLY : '0);
      end else begin
        rx_crc  <= rx_full[CRC_WIDTH-1:1];
      end

      if (bit_cnt == LAST_BIT) begin
        bit_cnt <= '0;
        crc     <= '0;
        if (crc == rx_full) begin
          flag_o <= 1'b1;
          data_o <= payload;
        end else begin
          flag_o <= 1'b0;
          data_o <= '0;
        end
      end else begin
        bit_cnt <= bit_cnt + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_checksum.sv
// Bench for checksum: directed frames from the test plan plus random frames against a long-division CRC model.
module tb_checksum;

  logic        clk_i;
  logic        rst_i;
  logic        en_i;
  logic        data_i;
  logic [63:0] data_o;
  logic        flag_o;

  int passed;
  int total;

  logic [63:0] exp_data;
  logic        exp_flag;

  checksum #(.DATA_WIDTH(64), .CRC_WIDTH(8), .POLY(8'h07)) dut (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .en_i   (en_i),
    .data_i (data_i),
    .data_o (data_o),
    .flag_o (flag_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Remainder of M(x)*x^8 mod (x^8+x^2+x+1); payload bit 0 is the highest-degree term.
  function automatic logic [7:0] ref_crc(input logic [63:0] p);
    logic [71:0] v;
    v = '0;
    for (int k = 0; k < 64; k++) v[71-k] = p[k];
    for (int i = 71; i >= 8; i--)
      if (v[i]) v[i -: 9] = v[i -: 9] ^ 9'h107;
    return v[7:0];
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) begin
      passed++;
    end else begin
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_flag"}, {63'd0, flag_o}, {63'd0, exp_flag});
    check({tag, "_data"}, data_o, exp_data);
  endtask

  task automatic send_bit(input logic b);
    en_i   = 1'b1;
    data_i = b;
    @(posedge clk_i);
    #1;
    en_i   = 1'b0;
    data_i = 1'($urandom);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      en_i   = 1'b0;
      data_i = 1'($urandom);
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic send_frame(input string tag, input logic [63:0] p, input logic [7:0] c,
                            input int pause_a, input int pause_b);
    for (int i = 0; i < 72; i++) begin
      if (i == 71) check_outputs({tag, "_hold"});
      send_bit((i < 64) ? p[i] : c[i-64]);
      if (i == pause_a || i == pause_b) begin
        idle(5);
        check_outputs({tag, "_pause"});
      end
    end
    if (ref_crc(p) == c) begin
      exp_flag = 1'b1;
      exp_data = p;
    end else begin
      exp_flag = 1'b0;
      exp_data = '0;
    end
    check_outputs(tag);
  endtask

  initial begin
    logic [63:0] p;
    logic [7:0]  c;
    passed   = 0;
    total    = 0;
    exp_flag = 1'b0;
    exp_data = '0;

    // Reset held with clocks and toggling data: nothing may advance.
    rst_i  = 1'b0;
    en_i   = 1'b1;
    data_i = 1'b0;
    for (int i = 0; i < 8; i++) begin
      data_i = ~data_i;
      @(posedge clk_i);
      #1;
    end
    check_outputs("reset");
    en_i  = 1'b0;
    #2;
    rst_i = 1'b1;
    idle(2);

    send_frame("zero", 64'h0, 8'h00, -1, -1);
    send_frame("bit63_ok", 64'h8000_0000_0000_0000, 8'h07, -1, -1);
    send_frame("bit63_bad", 64'h8000_0000_0000_0000, 8'h06, -1, -1);
    send_frame("bit62_ok", 64'h4000_0000_0000_0000, 8'h0E, -1, -1);
    send_frame("pause", 64'h8000_0000_0000_0000, 8'h07, 30, 66);

    // Pass frame immediately followed by a corrupted frame.
    p = {$urandom, $urandom};
    send_frame("b2b_pass", p, ref_crc(p), -1, -1);
    p = {$urandom, $urandom};
    send_frame("b2b_fail", p, ref_crc(p) ^ 8'h81, -1, -1);

    // Abort at bit 40 with a reset pulse, then a clean frame must pass.
    p = {$urandom, $urandom};
    send_frame("pre_abort", p, ref_crc(p), -1, -1);
    p = {$urandom, $urandom};
    for (int i = 0; i < 40; i++) send_bit(p[i]);
    #2;
    rst_i = 1'b0;
    #1;
    exp_flag = 1'b0;
    exp_data = '0;
    check_outputs("abort");
    idle(2);
    rst_i = 1'b1;
    idle(1);
    p = {$urandom, $urandom};
    send_frame("post_abort", p, ref_crc(p), -1, -1);

    // Random frames, some corrupted, some with random pauses.
    for (int n = 0; n < 24; n++) begin
      p = {$urandom, $urandom};
      c = ref_crc(p);
      if ($urandom_range(0, 1) == 1) c = c ^ 8'($urandom_range(1, 255));
      if ($urandom_range(0, 2) == 0)
        send_frame("rand_pause", p, c, $urandom_range(0, 70), $urandom_range(0, 70));
      else
        send_frame("rand", p, c, -1, -1);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/checksum.md
Name: checksum

Overview:
- Serial frame integrity checker in the PMU bitstream path.
- Receives frames one bit per clock. Each frame is a 64-bit payload followed by an 8-bit CRC.
- Computes CRC-8 over the payload, compares it with the received CRC, and presents the payload plus a pass/fail flag.

Parameters:
- DATA_WIDTH, 64, payload bits per frame.
- CRC_WIDTH, 8, checksum bits per frame. This is fixed at 8 for the POLY below.
- POLY, 8'h07, CRC generator polynomial x^8+x^2+x+1 (implicit x^8).

Ports:
- clk_i  input  1  system clock; all state changes on the rising edge.
- rst_i  input  1  reset; asynchronous, active-low.
- en_i  input  1  bit-valid; data_i is consumed on each rising edge where en_i=1.
- data_i  input  1  serial frame bit.
- data_o  output  DATA_WIDTH  payload of the last frame that passed the check.
- flag_o  output  1  result of the last completed frame: 1=CRC match, 0=mismatch or no frame yet.

Behaviour:
- Reset (rst_i=0, asynchronous): bit counter=0, crc=0, payload shift register=0, data_o=0, flag_o=0. Outputs stay 0 while rst_i is low.
- Frame format, in order on the wire: payload bit 0 … payload bit 63, then CRC bit 0 … CRC bit 7. Each field is LSB first.
- Bit counter runs 0..71 and advances only on clock edges with en_i=1.
- If en_i=0, the counter, CRC and shift registers hold; a frame may be paused mid-stream.
- Payload phase (counter 0..63):
  - Shift data_i into the payload register so that bit k lands at payload[k].
  - CRC update, serial with init 0x00: fb = crc[7] ^ data_i; crc <= {crc[6:0],1'b0} ^ (fb ? POLY : 0).
- CRC phase (counter 64..71): shift data_i into an 8-bit received-CRC register, LSB first.
- Completion edge (counter=71 with en_i=1), using the incoming bit as rx[7]:
  - If computed crc == received CRC: flag_o<=1 and data_o<=payload.
  - Otherwise: flag_o<=0 and data_o<=0.
  - Counter<=0, crc<=0.
- Latency: flag_o and data_o become valid on the same rising edge that samples the 72nd bit.
- flag_o and data_o hold until the next frame completes. They do not change mid-frame.
- Back-to-back frames: with en_i held high, the next bit after bit 71 is payload bit 0 of the next frame. No gap cycles are needed.
- Idle bits while en_i=1 are treated as frame bits. The upstream block must drop en_i between frames if it has nothing to send.
- Reset asserted mid-frame aborts the frame. The next frame starts at bit 0 after rst_i releases.
- No internal resynchronisation exists; alignment is purely by count from reset.

Test Plan:
- Reset: hold rst_i=0 with clocks running and data_i toggling -> data_o=0, flag_o=0; counter does not advance.
- Zero frame: 64 zero payload bits, then CRC 0x00, en_i=1 throughout -> flag_o=1, data_o=64'h0 on the edge sampling bit 71.
- Single-bit frame: payload bit 63=1, all others 0, then CRC 0x07 -> flag_o=1, data_o=64'h8000_0000_0000_0000. Repeat with CRC 0x06 -> flag_o=0, data_o=0.
- Shifted bit: payload bit 62=1 only, then CRC 0x0E -> flag_o=1, data_o=64'h4000_0000_0000_0000.
- Pause: repeat the single-bit frame with en_i dropped for 5 cycles after bit 30 and again after bit 66 -> same result as uninterrupted; flag_o/data_o unchanged until the final bit.
- Back-to-back and abort:
  - Pass frame then fail frame with no gap -> flag_o 1 then 0, data_o returns to 0.
  - Pulse rst_i low at bit 40 of a frame -> outputs 0; a following complete valid frame passes.
